// File: rtl/frag_cache_ctrl.sv
// Tag lookup and refill controller for the 4-bank fragment/texture line cache.
// Optional hit/miss counters are compiled in with FRAG_CACHE_STATS_EN.
module frag_cache_ctrl #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned OFF_W  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  input  logic [ADDR_W-1:0]       req_addr,
  output logic                    req_ready,
  input  logic [3:0]              lru,
  output logic                    read_en,
  output logic [3:0]              bank_hit,
  output logic                    rsp_valid,
  output logic [OFF_W-1:0]        rsp_offset,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic [ADDR_W-OFF_W-1:0] mem_req_addr,
  input  logic                    mem_rsp_valid,
  output logic [3:0]              fill_bank
`ifdef FRAG_CACHE_STATS_EN
  ,
  output logic [15:0]             hit_count,
  output logic [15:0]             miss_count
`endif
);

  localparam int unsigned TAG_W = ADDR_W - OFF_W;

  typedef enum logic [1:0] {StIdle, StLookup, StFillReq, StFillWait} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        victim_q, victim_d;
  logic [3:0]        valid_q, valid_d;
  logic [TAG_W-1:0]  tag_q [4];
  logic [TAG_W-1:0]  tag_d [4];

  logic [TAG_W-1:0]  lookup_tag;
  logic [3:0]        hit_vec;
  logic              hit;
  logic              lru_onehot;
  logic [3:0]        victim_sel;
  logic              accept;
  logic              fill_fire;

  assign lookup_tag = addr_q[ADDR_W-1:OFF_W];
  assign accept     = (state_q == StIdle) && req_valid;
  assign fill_fire  = (state_q == StFillWait) && mem_rsp_valid;

  always_comb begin
    hit_vec = '0;
    for (int i = 0; i < 4; i++) begin
      hit_vec[i] = valid_q[i] && (tag_q[i] == lookup_tag);
    end
  end

  assign hit = |hit_vec;

  // A malformed LRU vector (zero or multi-hot) falls back to bank 0.
  assign lru_onehot = (lru != 4'b0000) && ((lru & (lru - 4'd1)) == 4'b0000);

  always_comb begin
    victim_sel = 4'b0001;
    if (!valid_q[0])      victim_sel = 4'b0001;
    else if (!valid_q[1]) victim_sel = 4'b0010;
    else if (!valid_q[2]) victim_sel = 4'b0100;
    else if (!valid_q[3]) victim_sel = 4'b1000;
    else if (lru_onehot)  victim_sel = lru;
    else                  victim_sel = 4'b0001;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:     if (req_valid) state_d = StLookup;
      StLookup:   state_d = hit ? StIdle : StFillReq;
      StFillReq:  if (mem_req_ready) state_d = StFillWait;
      StFillWait: if (mem_rsp_valid) state_d = StLookup;
      default:    state_d = StIdle;
    endcase
  end

  // Datapath next-state: request latch, victim latch and tag array fill
  always_comb begin
    addr_d   = addr_q;
    victim_d = victim_q;
    valid_d  = valid_q;
    for (int i = 0; i < 4; i++) begin
      tag_d[i] = tag_q[i];
    end
    if (accept) begin
      addr_d = req_addr;
    end
    if ((state_q == StLookup) && !hit) begin
      victim_d = victim_sel;
    end
    if (fill_fire) begin
      for (int i = 0; i < 4; i++) begin
        if (victim_q[i]) begin
          valid_d[i] = 1'b1;
          tag_d[i]   = lookup_tag;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q   <= '0;
      victim_q <= '0;
      valid_q  <= '0;
      for (int i = 0; i < 4; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      addr_q   <= addr_d;
      victim_q <= victim_d;
      valid_q  <= valid_d;
      for (int i = 0; i < 4; i++) begin
        tag_q[i] <= tag_d[i];
      end
    end
  end

  // Outputs are forced low while rst is asserted so reset wins within its own cycle.
  always_comb begin
    req_ready     = 1'b0;
    read_en       = 1'b0;
    bank_hit      = 4'b0000;
    rsp_valid     = 1'b0;
    rsp_offset    = '0;
    mem_req_valid = 1'b0;
    mem_req_addr  = '0;
    fill_bank     = 4'b0000;
    if (!rst) begin
      case (state_q)
        StIdle: req_ready = 1'b1;
        StLookup: begin
          if (hit) begin
            read_en    = 1'b1;
            rsp_valid  = 1'b1;
            bank_hit   = hit_vec;
            rsp_offset = addr_q[OFF_W-1:0];
          end
        end
        StFillReq: begin
          mem_req_valid = 1'b1;
          mem_req_addr  = lookup_tag;
        end
        StFillWait: begin
          if (mem_rsp_valid) fill_bank = victim_q;
        end
        default: ;
      endcase
    end
  end

`ifdef FRAG_CACHE_STATS_EN
  logic        retry_q, retry_d;
  logic [15:0] hit_cnt_q, hit_cnt_d;
  logic [15:0] miss_cnt_q, miss_cnt_d;

  // Lookups that follow a fill are retries and are excluded from the hit count.
  always_comb begin
    retry_d    = retry_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (accept)    retry_d = 1'b0;
    if (fill_fire) retry_d = 1'b1;
    if (state_q == StLookup) begin
      if (hit && !retry_q && (hit_cnt_q != 16'hFFFF)) hit_cnt_d = hit_cnt_q + 16'd1;
      if (!hit && (miss_cnt_q != 16'hFFFF))           miss_cnt_d = miss_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      retry_q    <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      retry_q    <= retry_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_frag_cache_ctrl.sv
// Scoreboard bench for frag_cache_ctrl: expected hit responses are queued at request time
// and popped by a monitor when rsp_valid fires.
module tb_frag_cache_ctrl;

  localparam int ADDR_W = 16;
  localparam int OFF_W  = 2;
  localparam int TAG_W  = ADDR_W - OFF_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic              req_ready;
  logic [3:0]        lru = 4'b0001;
  logic              read_en;
  logic [3:0]        bank_hit;
  logic              rsp_valid;
  logic [OFF_W-1:0]  rsp_offset;
  logic              mem_req_valid;
  logic              mem_req_ready = 1'b0;
  logic [TAG_W-1:0]  mem_req_addr;
  logic              mem_rsp_valid = 1'b0;
  logic [3:0]        fill_bank;
`ifdef FRAG_CACHE_STATS_EN
  logic [15:0]       hit_count;
  logic [15:0]       miss_count;
`endif

  always #5 clk = ~clk;

  frag_cache_ctrl #(.ADDR_W(ADDR_W), .OFF_W(OFF_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_addr      (req_addr),
    .req_ready     (req_ready),
    .lru           (lru),
    .read_en       (read_en),
    .bank_hit      (bank_hit),
    .rsp_valid     (rsp_valid),
    .rsp_offset    (rsp_offset),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_rsp_valid (mem_rsp_valid),
    .fill_bank     (fill_bank)
`ifdef FRAG_CACHE_STATS_EN
    ,
    .hit_count     (hit_count),
    .miss_count    (miss_count)
`endif
  );

  typedef struct packed {
    logic [3:0]       bank;
    logic [OFF_W-1:0] off;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  // Response monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (rsp_valid) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_rsp: bank_hit=%b offset=%0d, required no response",
                   bank_hit, rsp_offset);
        end else begin
          mon_e = sb_q.pop_front();
          if ({read_en, bank_hit, rsp_offset} !== {1'b1, mon_e.bank, mon_e.off}) begin
            errors++;
            $display("FAIL rsp_data: read_en=%b bank_hit=%b offset=%0d, required 1 %b %0d",
                     read_en, bank_hit, rsp_offset, mon_e.bank, mon_e.off);
          end
        end
      end else if (read_en !== 1'b0 || bank_hit !== 4'b0000) begin
        checks++;
        errors++;
        $display("FAIL hit_without_rsp: read_en=%b bank_hit=%b, required 0 0000",
                 read_en, bank_hit);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_idle(input string name);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_idle_timeout: req_ready=%b, required 1", name, req_ready);
    end
  endtask

  task automatic do_req(input logic [ADDR_W-1:0] addr, input logic [3:0] bank,
                        input bit push);
    exp_t e;
    wait_idle("req");
    req_addr  = addr;
    req_valid = 1'b1;
    if (push) begin
      e.bank = bank;
      e.off  = addr[OFF_W-1:0];
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic serve_fill(input logic [TAG_W-1:0] exp_addr, input logic [3:0] exp_fill,
                            input int stall);
    bit found = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_req_valid === 1'b1) begin
        found = 1;
        break;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL fill_req_timeout: mem_req_valid=%b, required 1", mem_req_valid);
      return;
    end
    checks++;
    if (mem_req_addr !== exp_addr) begin
      errors++;
      $display("FAIL mem_req_addr: got %h, required %h", mem_req_addr, exp_addr);
    end
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      checks++;
      if ({mem_req_valid, mem_req_addr, req_ready} !== {1'b1, exp_addr, 1'b0}) begin
        errors++;
        $display("FAIL fill_stall: valid=%b addr=%h req_ready=%b, required 1 %h 0",
                 mem_req_valid, mem_req_addr, req_ready, exp_addr);
      end
    end
    mem_req_ready = 1'b1;
    @(posedge clk);
    #1 mem_req_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL mem_req_drop: mem_req_valid=%b, required 0", mem_req_valid);
    end
    mem_rsp_valid = 1'b1;
    #1;
    checks++;
    if (fill_bank !== exp_fill) begin
      errors++;
      $display("FAIL fill_bank: got %b, required %b", fill_bank, exp_fill);
    end
    @(posedge clk);
    #1 mem_rsp_valid = 1'b0;
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({req_ready, read_en, bank_hit, rsp_valid, rsp_offset, mem_req_valid, mem_req_addr,
         fill_bank} !== '0) begin
      errors++;
      $display("FAIL reset_held_outputs: req_ready=%b read_en=%b mem_req_valid=%b fill=%b, required all 0",
               req_ready, read_en, mem_req_valid, fill_bank);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({req_ready, read_en, bank_hit, rsp_valid, mem_req_valid, fill_bank} !== 12'h800) begin
      errors++;
      $display("FAIL reset_release: req_ready=%b read_en=%b mem_req_valid=%b fill=%b, required 1 0 0 0",
               req_ready, read_en, mem_req_valid, fill_bank);
    end
  endtask

  task automatic test_miss_fill();
    do_req(16'h1234, 4'b0001, 1);
    serve_fill(14'h048D, 4'b0001, 0);
    wait_idle("miss_fill");
`ifdef FRAG_CACHE_STATS_EN
    checks++;
    if ({hit_count, miss_count} !== {16'd0, 16'd1}) begin
      errors++;
      $display("FAIL stats_first_miss: hit=%0d miss=%0d, required 0 1", hit_count, miss_count);
    end
`endif
  endtask

  task automatic test_fill_all();
    apply_reset();
    for (int b = 0; b < 4; b++) begin
      logic [ADDR_W-1:0] a;
      logic [3:0] oh;
      a  = ADDR_W'(b * 4);
      oh = 4'b0001 << b;
      do_req(a, oh, 1);
      serve_fill(TAG_W'(b), oh, 0);
    end
    do_req(16'h0005, 4'b0010, 1);
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL hit_latency: rsp_valid=%b, required 1", rsp_valid);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (mem_req_valid !== 1'b0) begin
        errors++;
        $display("FAIL hit_no_fetch: mem_req_valid=%b, required 0", mem_req_valid);
      end
      @(negedge clk);
    end
`ifdef FRAG_CACHE_STATS_EN
    checks++;
    if ({hit_count, miss_count} !== {16'd1, 16'd4}) begin
      errors++;
      $display("FAIL stats_fill_all: hit=%0d miss=%0d, required 1 4", hit_count, miss_count);
    end
`endif
  endtask

  task automatic test_lru_victim();
    lru = 4'b0100;
    do_req(16'h0100, 4'b0100, 1);
    serve_fill(14'h0040, 4'b0100, 0);
    lru = 4'b1000;
    do_req(16'h0008, 4'b1000, 1);
    serve_fill(14'h0002, 4'b1000, 0);
  endtask

  task automatic test_lru_not_onehot();
    lru = 4'b0110;
    do_req(16'h0200, 4'b0001, 1);
    serve_fill(14'h0080, 4'b0001, 0);
  endtask

  task automatic test_backpressure();
    lru = 4'b0010;
    do_req(16'h0333, 4'b0010, 1);
    serve_fill(14'h00CC, 4'b0010, 5);
  endtask

  task automatic test_back_to_back();
    exp_t e;
    wait_idle("b2b");
    req_addr  = 16'h0203;
    req_valid = 1'b1;
    e.bank = 4'b0001; e.off = 2'd3;
    sb_q.push_back(e);
    @(posedge clk);
    #1 req_addr = 16'h0331;
    e.bank = 4'b0010; e.off = 2'd1;
    sb_q.push_back(e);
    @(negedge clk);
    checks++;
    if ({rsp_valid, req_ready} !== 2'b10) begin
      errors++;
      $display("FAIL b2b_first: rsp_valid=%b req_ready=%b, required 1 0", rsp_valid, req_ready);
    end
    @(negedge clk);
    checks++;
    if ({rsp_valid, req_ready} !== 2'b01) begin
      errors++;
      $display("FAIL b2b_gap: rsp_valid=%b req_ready=%b, required 0 1", rsp_valid, req_ready);
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second: rsp_valid=%b, required 1", rsp_valid);
    end
    // Stray memory response while idle must not write a bank.
    @(negedge clk);
    mem_rsp_valid = 1'b1;
    #1;
    checks++;
    if ({fill_bank, req_ready} !== 5'b00001) begin
      errors++;
      $display("FAIL stray_rsp_idle: fill_bank=%b req_ready=%b, required 0000 1",
               fill_bank, req_ready);
    end
    @(posedge clk);
    #1 mem_rsp_valid = 1'b0;
  endtask

  task automatic test_reset_in_fill();
    bit found = 0;
    lru = 4'b1000;
    do_req(16'h0400, 4'b0000, 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_req_valid === 1'b1) begin
        found = 1;
        break;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL abort_fill_req: mem_req_valid=%b, required 1", mem_req_valid);
    end
    mem_req_ready = 1'b1;
    @(posedge clk);
    #1 mem_req_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({req_ready, read_en, bank_hit, rsp_valid, mem_req_valid, mem_req_addr, fill_bank}
        !== {1'b1, 25'd0}) begin
      errors++;
      $display("FAIL abort_outputs: req_ready=%b mem_req_valid=%b fill=%b, required 1 0 0000",
               req_ready, mem_req_valid, fill_bank);
    end
    mem_rsp_valid = 1'b1;
    #1;
    checks++;
    if (fill_bank !== 4'b0000) begin
      errors++;
      $display("FAIL late_rsp: fill_bank=%b, required 0000", fill_bank);
    end
    @(posedge clk);
    #1 mem_rsp_valid = 1'b0;
`ifdef FRAG_CACHE_STATS_EN
    checks++;
    if ({hit_count, miss_count} !== 32'd0) begin
      errors++;
      $display("FAIL stats_reset: hit=%0d miss=%0d, required 0 0", hit_count, miss_count);
    end
`endif
    // All valid bits cleared: victim must be bank 0 regardless of lru.
    do_req(16'h0000, 4'b0001, 1);
    serve_fill(14'h0000, 4'b0001, 0);
  endtask

  initial begin
    test_reset();
    test_miss_fill();
    test_fill_all();
    test_lru_victim();
    test_lru_not_onehot();
    test_backpressure();
    test_back_to_back();
    test_reset_in_fill();
    wait_idle("final");
    repeat (3) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL missing_rsp: %0d responses outstanding, required 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/frag_cache_ctrl.md
Name: frag_cache_ctrl

Overview:
- Tag lookup and refill controller for the rasterizer's 4-bank fragment/texture line cache.
- Accepts fragment read requests, compares the tag against four bank tags, and reports hits to the LRU tracker via read_en/bank_hit.
- On a miss, takes the tracker's one-hot lru output as the victim, fetches the line from memory and retries the lookup.
- Sits directly upstream of the LRU tracker, which consumes read_en/bank_hit and produces lru.

Parameters:
- ADDR_W, 16, fragment word address width.
- OFF_W, 2, word-offset bits within a line (4 words/line).
- Derived, not a parameter: tag width TAG_W = ADDR_W-OFF_W.

Ports:
- clk  in  1  system clock, all state changes on posedge.
- rst  in  1  reset; synchronous, active-high.
- req_valid  in  1  request present.
- req_addr  in  ADDR_W  fragment word address.
- req_ready  out  1  controller can accept; high only in IDLE.
- lru  in  4  one-hot least-recently-used bank from the LRU tracker.
- read_en  out  1  single-cycle pulse on every lookup hit.
- bank_hit  out  4  one-hot hit bank; 0 when read_en low.
- rsp_valid  out  1  response pulse, coincident with read_en.
- rsp_offset  out  OFF_W  word offset of the hit access.
- mem_req_valid  out  1  line fetch request.
- mem_req_ready  in  1  memory accepts fetch.
- mem_req_addr  out  TAG_W  line address (req_addr >> OFF_W).
- mem_rsp_valid  in  1  fetched line data present this cycle.
- fill_bank  out  4  one-hot data-bank write enable, 1-cycle pulse.

Behaviour:
- Reset, synchronous: state IDLE; all 4 tag-valid bits cleared; all outputs 0 except req_ready, which is 1 the cycle after rst deasserts. Reset overrides all other activity in the same cycle.
- State storage: 4 entries of {valid, TAG_W tag}; latched addr register; latched victim register (4 bits).
- IDLE:
  - req_ready=1.
  - On req_valid, latch req_addr and go to LOOKUP.
- LOOKUP: compare latched tag with each valid entry.
  - Hit: read_en=1, rsp_valid=1, bank_hit=matching bank, rsp_offset=addr[OFF_W-1:0]; go to IDLE.
  - Hit latency: response in the cycle after acceptance. Back-to-back hits therefore sustain one request per 2 cycles.
  - Miss: read_en=0; latch victim; go to FILL_REQ.
  - Victim priority: (1) the lowest-index invalid bank, if any; (2) otherwise lru, if it is exactly one-hot; (3) otherwise bank 0.
  - Multiple matches cannot occur, since fills never duplicate a tag.
- FILL_REQ:
  - mem_req_valid=1 and mem_req_addr=latched tag, both held stable until mem_req_ready.
  - On mem_req_ready, go to FILL_WAIT; mem_req_valid drops the next cycle.
- FILL_WAIT:
  - Wait indefinitely for mem_rsp_valid.
  - On mem_rsp_valid: fill_bank=victim for 1 cycle; tag[victim]=latched tag; valid[victim]=1; go to LOOKUP.
  - The retry lookup then hits, so the LRU tracker is updated only through the hit path.
- mem_rsp_valid is ignored in every state except FILL_WAIT. mem_req_ready is ignored outside FILL_REQ.
- A new request is never accepted while a miss is outstanding (req_ready=0 outside IDLE).
- Reset during FILL_REQ or FILL_WAIT abandons the fill: no tag is written, and a late mem_rsp_valid is ignored.
- No wrap or arithmetic beyond the slicing above. Tag and offset come purely from bit fields of req_addr.

Optional Feature:
- Macro: FRAG_CACHE_STATS_EN.
- Defined: adds output ports hit_count[15:0] and miss_count[15:0].
  - hit_count increments on each first-try LOOKUP hit (retry hits after a fill are not counted).
  - miss_count increments on each LOOKUP miss.
  - Both saturate at 16'hFFFF and clear on rst.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- After rst, req 0x1234 -> miss, victim bank0, mem_req_addr=0x48D; then mem_rsp_valid -> fill_bank=4'b0001; next cycle rsp_valid=1, bank_hit=4'b0001, rsp_offset=0.
- Fill 0x0000, 0x0004, 0x0008, 0x000C (banks 0-3), then req 0x0005 -> rsp_valid one cycle after accept, bank_hit=4'b0010, rsp_offset=1, no mem_req_valid.
- All banks valid, lru=4'b0100, req 0x0100 -> mem_req_addr=0x040, fill_bank=4'b0100; subsequent req 0x0008 misses.
- All valid, lru=4'b0110 (not one-hot), req 0x0200 -> victim bank0 (fill_bank=4'b0001).
- mem_req_ready low for 5 cycles -> mem_req_valid and mem_req_addr stable, req_ready=0 throughout.
- rst asserted in FILL_WAIT -> next cycle all outputs 0; mem_rsp_valid pulse afterwards gives fill_bank=0; req 0x0000 then misses. With FRAG_CACHE_STATS_EN, counters read 0 after reset.
